// File: rtl/sme_match_arbiter_if.sv
// rtl/sme_match_arbiter_if.sv - per-lane match inputs and single registered match output of the SME arbiter
interface sme_match_arbiter_if #(
    parameter int LANES    = 8,
    parameter int ID_WIDTH = 16
);
    localparam int LANE_W = $clog2(LANES);

    logic [LANES-1:0]          in_valid;
    logic [LANES*ID_WIDTH-1:0] in_rule_id;
    logic [LANES-1:0]          in_last;
    logic [LANES-1:0]          in_ready;
    logic                      out_valid;
    logic [ID_WIDTH-1:0]       out_rule_id;
    logic [LANE_W-1:0]         out_lane;
    logic                      out_last;
    logic                      out_ready;

    modport slave (
        input  in_valid, in_rule_id, in_last, out_ready,
        output in_ready, out_valid, out_rule_id, out_lane, out_last
    );

    modport master (
        output in_valid, in_rule_id, in_last, out_ready,
        input  in_ready, out_valid, out_rule_id, out_lane, out_last
    );
endinterface

// File: rtl/sme_match_arbiter.sv
// rtl/sme_match_arbiter.sv - round-robin packet-locking merge of SME match lanes; SME_ARB_STAT_EN adds per-lane match counters
module sme_match_arbiter #(
    parameter int  LANES    = 8,
    parameter int  ID_WIDTH = 16,
    localparam int LANE_W   = $clog2(LANES)
) (
    input  logic               clk,
    input  logic               rst,
    sme_match_arbiter_if.slave m,
    output logic               busy,
    input  logic [LANE_W-1:0]  stat_sel,
    input  logic               stat_clear,
    output logic [31:0]        stat_count
);
    typedef enum logic {IDLE, LOCKED} state_t;

    state_t              state_q, state_d;
    logic [LANE_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [LANE_W-1:0]   lock_lane_q, lock_lane_d;
    logic                out_valid_q, out_valid_d;
    logic [ID_WIDTH-1:0] out_rule_id_q, out_rule_id_d;
    logic [LANE_W-1:0]   out_lane_q, out_lane_d;
    logic                out_last_q, out_last_d;

    logic [LANE_W-1:0]   grant;
    logic [LANE_W-1:0]   idx;
    logic                found;
    logic                slot_free;
    logic                accept;
    logic                acc_last;
    logic [ID_WIDTH-1:0] acc_id;

    always_comb begin
        grant         = lock_lane_q;
        idx           = '0;
        found         = 1'b0;
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        lock_lane_d   = lock_lane_q;
        out_valid_d   = out_valid_q;
        out_rule_id_d = out_rule_id_q;
        out_lane_d    = out_lane_q;
        out_last_d    = out_last_q;

        // A held lock ignores every other lane, even if the locked lane is idle.
        if (state_q == LOCKED) begin
            found = m.in_valid[lock_lane_q];
        end else begin
            for (int i = 0; i < LANES; i++) begin
                idx = rr_ptr_q + LANE_W'(i);
                if (!found && m.in_valid[idx]) begin
                    grant = idx;
                    found = 1'b1;
                end
            end
        end

        slot_free  = !out_valid_q || m.out_ready;
        accept     = found && slot_free && !rst;
        acc_last   = m.in_last[grant];
        acc_id     = m.in_rule_id[grant*ID_WIDTH +: ID_WIDTH];
        m.in_ready = accept ? (LANES'(1) << grant) : '0;

        if (accept) begin
            out_valid_d   = 1'b1;
            out_rule_id_d = acc_id;
            out_lane_d    = grant;
            out_last_d    = acc_last;
            case (state_q)
                IDLE: begin
                    if (acc_last) begin
                        rr_ptr_d = grant + LANE_W'(1);
                    end else begin
                        state_d     = LOCKED;
                        lock_lane_d = grant;
                    end
                end
                LOCKED: begin
                    if (acc_last) begin
                        state_d  = IDLE;
                        rr_ptr_d = lock_lane_q + LANE_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (m.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            lock_lane_q   <= '0;
            out_valid_q   <= 1'b0;
            out_rule_id_q <= '0;
            out_lane_q    <= '0;
            out_last_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            lock_lane_q   <= lock_lane_d;
            out_valid_q   <= out_valid_d;
            out_rule_id_q <= out_rule_id_d;
            out_lane_q    <= out_lane_d;
            out_last_q    <= out_last_d;
        end
    end

    assign m.out_valid   = out_valid_q;
    assign m.out_rule_id = out_rule_id_q;
    assign m.out_lane    = out_lane_q;
    assign m.out_last    = out_last_q;
    assign busy          = (state_q == LOCKED);

`ifdef SME_ARB_STAT_EN
    logic [31:0] cnt_q [LANES];
    logic [31:0] stat_count_q;

    // Clear wins over a same-cycle increment; counters saturate at all-ones.
    always_ff @(posedge clk) begin
        if (rst || stat_clear) begin
            for (int i = 0; i < LANES; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (accept && grant == LANE_W'(i) && cnt_q[i] != 32'hFFFF_FFFF)
                    cnt_q[i] <= cnt_q[i] + 32'd1;
            end
        end
        if (rst) stat_count_q <= '0;
        else     stat_count_q <= cnt_q[stat_sel];
    end

    assign stat_count = stat_count_q;
`else
    logic unused_stat;
    assign unused_stat = ^{stat_sel, stat_clear};
    assign stat_count  = '0;
`endif
endmodule

// File: tb/tb_sme_match_arbiter.sv
// tb/tb_sme_match_arbiter.sv - scoreboard bench for sme_match_arbiter with per-lane queued sources
module tb_sme_match_arbiter;
    localparam int LANES = 8;
    localparam int IDW   = 16;

    typedef struct packed {
        logic [2:0]  lane;
        logic [15:0] id;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        busy;
    logic [2:0]  stat_sel = '0;
    logic        stat_clear = 1'b0;
    logic [31:0] stat_count;

    int n_cmp = 0;
    int n_bad = 0;

    exp_t        exp_q[$];
    logic [16:0] lmem [LANES][32];
    int          head [LANES];
    int          tail [LANES];

    sme_match_arbiter_if #(.LANES(LANES), .ID_WIDTH(IDW)) bus();

    sme_match_arbiter #(.LANES(LANES), .ID_WIDTH(IDW)) dut (
        .clk        (clk),
        .rst        (rst),
        .m          (bus),
        .busy       (busy),
        .stat_sel   (stat_sel),
        .stat_clear (stat_clear),
        .stat_count (stat_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic beat(input int lane, input logic [15:0] id, input logic last);
        lmem[lane][tail[lane]] = {id, last};
        tail[lane]++;
    endtask

    task automatic expect_beat(input int lane, input logic [15:0] id, input logic last);
        exp_t e;
        e.lane = 3'(lane);
        e.id   = id;
        e.last = last;
        exp_q.push_back(e);
    endtask

    function automatic bit sources_empty();
        for (int i = 0; i < LANES; i++) if (head[i] != tail[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_drain(input string name);
        int k;
        for (k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            if (exp_q.size() == 0 && sources_empty() && !bus.out_valid) break;
        end
        chk({name, "_drain_timeout"}, (k >= 200) ? 32'd1 : 32'd0, 32'd0);
    endtask

    // Lane sources: retire the beat acked at the edge, then present the next one.
    initial begin
        logic [LANES-1:0] acc;
        for (int i = 0; i < LANES; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        bus.in_valid   = '0;
        bus.in_rule_id = '0;
        bus.in_last    = '0;
        forever begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk); #2;
            for (int i = 0; i < LANES; i++) begin
                if (acc[i]) head[i]++;
                bus.in_valid[i] = (head[i] < tail[i]);
                if (head[i] < tail[i]) begin
                    bus.in_rule_id[i*IDW +: IDW] = lmem[i][head[i]][16:1];
                    bus.in_last[i]               = lmem[i][head[i]][0];
                end else begin
                    bus.in_rule_id[i*IDW +: IDW] = '0;
                    bus.in_last[i]               = 1'b0;
                end
            end
        end
    end

    // Monitor: every beat handed downstream is checked against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", {16'h0, bus.out_rule_id}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_rule_id", {16'h0, bus.out_rule_id}, {16'h0, e.id});
                    chk("out_lane",    {29'h0, bus.out_lane},    {29'h0, e.lane});
                    chk("out_last",    {31'h0, bus.out_last},    {31'h0, e.last});
                    chk("busy_vs_beat", {31'h0, busy},           {31'h0, !e.last});
                end
            end
        end
    end

    initial begin
        int k;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid",   {31'h0, bus.out_valid},   32'd0);
        chk("rst_out_rule_id", {16'h0, bus.out_rule_id}, 32'd0);
        chk("rst_out_lane",    {29'h0, bus.out_lane},    32'd0);
        chk("rst_out_last",    {31'h0, bus.out_last},    32'd0);
        chk("rst_busy",        {31'h0, busy},            32'd0);
        chk("rst_in_ready",    {24'h0, bus.in_ready},    32'd0);
        chk("rst_stat_count",  stat_count,               32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Round robin from reset, then pointer lands on lane 6.
        beat(0, 16'h0010, 1'b1); beat(3, 16'h0033, 1'b1); beat(5, 16'h0055, 1'b1);
        expect_beat(0, 16'h0010, 1'b1); expect_beat(3, 16'h0033, 1'b1); expect_beat(5, 16'h0055, 1'b1);
        wait_drain("rr");
        beat(5, 16'h0505, 1'b1); beat(6, 16'h0606, 1'b1); beat(7, 16'h0707, 1'b1);
        expect_beat(6, 16'h0606, 1'b1); expect_beat(7, 16'h0707, 1'b1); expect_beat(5, 16'h0505, 1'b1);
        wait_drain("rr_ptr6");

        // Packet lock: lane 2 keeps the output while lane 1 waits.
        beat(2, 16'h0201, 1'b0); beat(2, 16'h0202, 1'b0); beat(2, 16'h0203, 1'b1);
        expect_beat(2, 16'h0201, 1'b0); expect_beat(2, 16'h0202, 1'b0);
        expect_beat(2, 16'h0203, 1'b1); expect_beat(1, 16'h0101, 1'b1);
        @(posedge clk); #1;
        beat(1, 16'h0101, 1'b1);
        wait_drain("lock");

        // Backpressure.
        bus.out_ready = 1'b0;
        beat(0, 16'h0AA1, 1'b1); beat(1, 16'h0BB1, 1'b1);
        expect_beat(0, 16'h0AA1, 1'b1); expect_beat(1, 16'h0BB1, 1'b1);
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.out_valid) break;
        end
        chk("bp_valid_timeout", (k >= 50) ? 32'd1 : 32'd0, 32'd0);
        for (int c = 0; c < 4; c++) begin
            chk("bp_in_ready",    {24'h0, bus.in_ready},    32'd0);
            chk("bp_out_rule_id", {16'h0, bus.out_rule_id}, 32'h0AA1);
            @(negedge clk);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        wait_drain("bp");

        // Locked stall: lane 6 must wait for lane 4's last beat.
        beat(4, 16'h0401, 1'b0);
        expect_beat(4, 16'h0401, 1'b0); expect_beat(4, 16'h0402, 1'b1); expect_beat(6, 16'h0601, 1'b1);
        repeat (2) @(posedge clk); #1;
        beat(6, 16'h0601, 1'b1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("stall_in_ready", {24'h0, bus.in_ready}, 32'd0);
            chk("stall_busy",     {31'h0, busy},         32'd1);
        end
        @(posedge clk); #1;
        beat(4, 16'h0402, 1'b1);
        wait_drain("stall");

        // Reset while lane 7 holds the lock.
        beat(7, 16'h0701, 1'b0);
        expect_beat(7, 16'h0701, 1'b0);
        repeat (3) @(posedge clk); #1;
        chk("pre_rst_busy", {31'h0, busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("post_rst_busy",      {31'h0, busy},          32'd0);
        chk("post_rst_out_valid", {31'h0, bus.out_valid}, 32'd0);
        beat(0, 16'h0001, 1'b1); beat(7, 16'h0702, 1'b1);
        expect_beat(0, 16'h0001, 1'b1); expect_beat(7, 16'h0702, 1'b1);
        wait_drain("rst_mid");

`ifdef SME_ARB_STAT_EN
        stat_clear = 1'b1;
        @(posedge clk); #1;
        stat_clear = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            beat(3, 16'h0300 + 16'(i), 1'b1);
            expect_beat(3, 16'h0300 + 16'(i), 1'b1);
        end
        wait_drain("stat");
        stat_sel = 3'd3;
        @(posedge clk); #1;
        chk("stat_count_lane3", stat_count, 32'd5);
        stat_clear = 1'b1;
        @(posedge clk); #1;
        stat_clear = 1'b0;
        @(posedge clk); #1;
        chk("stat_count_cleared", stat_count, 32'd0);
`else
        stat_sel   = 3'd3;
        stat_clear = 1'b1;
        @(posedge clk); #1;
        stat_clear = 1'b0;
        chk("stat_count_tied", stat_count, 32'd0);
`endif

        repeat (2) @(posedge clk); #1;
        chk("scoreboard_left", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
